small_sync_fifo: RTL

//  Single-clock FIFO: parametrised successor to the PCS small dual-clock FIFO.

---
 rtl/small_sync_fifo_pkg.sv | 25 ++
 rtl/sync_fifo_mem.sv | 26 ++
 rtl/small_sync_fifo.sv | 136 +++++++++++++
 3 files changed

// File: rtl/small_sync_fifo_pkg.sv
// Shared defaults and types for the PCS single-clock FIFO family.
package small_sync_fifo_pkg;

    localparam int unsigned PCS_DSIZE = 18;
    localparam int unsigned PCS_ASIZE = 3;

    // Read-mode encodings for the FWFT parameter
    localparam int unsigned FWFT_REGISTERED  = 0;
    localparam int unsigned FWFT_FALLTHROUGH = 1;

    typedef struct packed {
        logic wfull;
        logic w_almost_full;
        logic rempty;
        logic r_almost_empty;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RESET = '{
        wfull:          1'b0,
        w_almost_full:  1'b0,
        rempty:         1'b1,
        r_almost_empty: 1'b1
    };

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DSIZE storage: clocked write port, combinational read port, no reset.
module sync_fifo_mem #(
    parameter int unsigned DSIZE = 18,
    parameter int unsigned ASIZE = 3
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [ASIZE-1:0] waddr_i,
    input  logic [DSIZE-1:0] wdata_i,
    input  logic [ASIZE-1:0] raddr_i,
    output logic [DSIZE-1:0] rdata_o
);

    localparam int unsigned DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/small_sync_fifo.sv
// Single-clock FIFO with exact occupancy, FWFT or registered read, flush and sticky errors.
module small_sync_fifo
    import small_sync_fifo_pkg::*;
#(
    parameter int unsigned DSIZE             = PCS_DSIZE,
    parameter int unsigned ASIZE             = PCS_ASIZE,
    parameter int unsigned ALMOST_FULL_SIZE  = 4,
    parameter int unsigned ALMOST_EMPTY_SIZE = 3,
    parameter int unsigned FWFT              = FWFT_REGISTERED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    output logic             wfull,
    output logic             w_almost_full,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rvalid,
    output logic             rempty,
    output logic             r_almost_empty,
    output logic [ASIZE:0]   count,
    output logic             overflow,
    output logic             underflow,
    input  logic             err_clr
);

    localparam int unsigned DEPTH = 1 << ASIZE;
    localparam int unsigned CW    = ASIZE + 1;

    if (ASIZE < 1) begin : g_bad_asize
        $error("small_sync_fifo: ASIZE must be >= 1");
    end
    if (ALMOST_FULL_SIZE < 1 || ALMOST_FULL_SIZE > DEPTH) begin : g_bad_af
        $error("small_sync_fifo: ALMOST_FULL_SIZE must be in 1..DEPTH");
    end
    if (ALMOST_EMPTY_SIZE > DEPTH - 1) begin : g_bad_ae
        $error("small_sync_fifo: ALMOST_EMPTY_SIZE must be in 0..DEPTH-1");
    end

    logic [CW-1:0]    wbin_q, wbin_d, rbin_q, rbin_d, count_q, count_d;
    fifo_flags_t      flags_q, flags_d;
    logic             overflow_q, overflow_d, underflow_q, underflow_d;
    logic             wacc_c, racc_c;
    logic [DSIZE-1:0] mem_rdata;

    // Acceptance and next state; flags derive from count_d so they are exact
    always_comb begin
        wacc_c      = winc & ~flags_q.wfull & ~flush;
        racc_c      = rinc & ~flags_q.rempty & ~flush;
        wbin_d      = wbin_q + CW'(wacc_c);
        rbin_d      = rbin_q + CW'(racc_c);
        count_d     = count_q + CW'(wacc_c) - CW'(racc_c);
        overflow_d  = (overflow_q & ~err_clr) | (winc & flags_q.wfull & ~flush);
        underflow_d = (underflow_q & ~err_clr) | (rinc & flags_q.rempty & ~flush);
        if (flush) begin
            wbin_d  = '0;
            rbin_d  = '0;
            count_d = '0;
        end
        flags_d.wfull          = (count_d == CW'(DEPTH));
        flags_d.w_almost_full  = (count_d >= CW'(ALMOST_FULL_SIZE));
        flags_d.rempty         = (count_d == '0);
        flags_d.r_almost_empty = (count_d <= CW'(ALMOST_EMPTY_SIZE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q      <= '0;
            rbin_q      <= '0;
            count_q     <= '0;
            flags_q     <= FLAGS_RESET;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wbin_q      <= wbin_d;
            rbin_q      <= rbin_d;
            count_q     <= count_d;
            flags_q     <= flags_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk     (clk),
        .we_i    (wacc_c),
        .waddr_i (wbin_q[ASIZE-1:0]),
        .wdata_i (wdata),
        .raddr_i (rbin_q[ASIZE-1:0]),
        .rdata_o (mem_rdata)
    );

    if (FWFT != 0) begin : g_fwft
        assign rdata  = mem_rdata;
        assign rvalid = ~flags_q.rempty;
    end else begin : g_reg_read
        logic [DSIZE-1:0] rdata_q, rdata_d;
        logic             rvalid_q, rvalid_d;

        // rdata holds its last value unless a read is accepted
        always_comb begin
            rdata_d  = rdata_q;
            rvalid_d = racc_c;
            if (racc_c) begin
                rdata_d = mem_rdata;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rdata_q  <= rdata_d;
                rvalid_q <= rvalid_d;
            end
        end

        assign rdata  = rdata_q;
        assign rvalid = rvalid_q;
    end

    assign wfull          = flags_q.wfull;
    assign w_almost_full  = flags_q.w_almost_full;
    assign rempty         = flags_q.rempty;
    assign r_almost_empty = flags_q.r_almost_empty;
    assign count          = count_q;
    assign overflow       = overflow_q;
    assign underflow      = underflow_q;

endmodule
